// File: rtl/branch_predict_ctrl.sv
// Static JAL / BHT-based conditional-branch predictor with mispredict redirect and a RUN/RECOVER FSM.
// Optional statistics counters are enabled by defining BRANCH_PREDICT_STATS_EN.
module branch_predict_ctrl #(
  parameter int BHT_ENTRIES    = 16,
  parameter int RECOVER_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_if_pc,
  input  logic [31:0] i_if_instr,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_pc,
  input  logic        i_ex_valid,
  input  logic        i_ex_is_branch,
  input  logic        i_ex_is_jump,
  input  logic [31:0] i_ex_pc,
  input  logic        i_ex_taken,
  input  logic [31:0] i_ex_target,
  input  logic        i_ex_pred_taken,
  input  logic [31:0] i_ex_pred_pc,
  input  logic        i_stall,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_flush,
  output logic        o_recover
`ifdef BRANCH_PREDICT_STATS_EN
  ,
  output logic [31:0] o_branch_cnt,
  output logic [31:0] o_mispred_cnt
`endif
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  typedef enum logic {
    RUN     = 1'b0,
    RECOVER = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] rcnt_q, rcnt_d;
  logic [1:0] bht_q [BHT_ENTRIES];
  logic [1:0] bht_d [BHT_ENTRIES];

  logic [4:0]       opcode;
  logic [31:0]      j_imm, b_imm;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic             resolve, mispredict;
  logic             unused_instr_bits;

  assign opcode = i_if_instr[6:2];
  assign j_imm  = {{12{i_if_instr[31]}}, i_if_instr[19:12], i_if_instr[20], i_if_instr[30:21], 1'b0};
  assign b_imm  = {{20{i_if_instr[31]}}, i_if_instr[7], i_if_instr[30:25], i_if_instr[11:8], 1'b0};
  assign rd_idx = i_if_pc[IDX_W+1:2];
  assign wr_idx = i_ex_pc[IDX_W+1:2];
  assign unused_instr_bits = ^i_if_instr[1:0];

  // Reads use the registered table, so a same-cycle update is not visible until the next cycle.
  always_comb begin
    o_pred_taken = 1'b0;
    o_pred_pc    = i_if_pc + 32'd4;
    if (opcode == 5'b11011) begin
      o_pred_taken = 1'b1;
      o_pred_pc    = i_if_pc + j_imm;
    end else if (opcode == 5'b11000) begin
      o_pred_taken = bht_q[rd_idx][1];
      if (bht_q[rd_idx][1]) o_pred_pc = i_if_pc + b_imm;
    end
  end

  assign resolve    = i_ex_valid & (i_ex_is_branch | i_ex_is_jump) & ~i_stall & (state_q == RUN);
  assign mispredict = resolve & ((i_ex_taken != i_ex_pred_taken) |
                                 (i_ex_taken & (i_ex_target != i_ex_pred_pc)));

  always_comb begin
    o_redirect    = 1'b0;
    o_flush       = 1'b0;
    o_redirect_pc = 32'd0;
    if (mispredict) begin
      o_redirect    = 1'b1;
      o_flush       = 1'b1;
      o_redirect_pc = i_ex_taken ? i_ex_target : (i_ex_pc + 32'd4);
    end
  end

  always_comb begin
    for (int i = 0; i < BHT_ENTRIES; i++) bht_d[i] = bht_q[i];
    if (resolve && i_ex_is_branch) begin
      if (i_ex_taken && bht_q[wr_idx] != 2'd3)
        bht_d[wr_idx] = bht_q[wr_idx] + 2'd1;
      else if (!i_ex_taken && bht_q[wr_idx] != 2'd0)
        bht_d[wr_idx] = bht_q[wr_idx] - 2'd1;
    end
  end

  // RECOVER lasts RECOVER_CYCLES cycles and counts down regardless of stall.
  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    case (state_q)
      RUN: begin
        if (mispredict) begin
          state_d = RECOVER;
          rcnt_d  = 3'(RECOVER_CYCLES);
        end
      end
      RECOVER: begin
        if (rcnt_q <= 3'd1) begin
          state_d = RUN;
          rcnt_d  = 3'd0;
        end else begin
          rcnt_d = rcnt_q - 3'd1;
        end
      end
      default: begin
        state_d = RUN;
        rcnt_d  = 3'd0;
      end
    endcase
  end

  assign o_recover = (state_q == RECOVER);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= RUN;
      rcnt_q  <= 3'd0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= bht_d[i];
    end
  end

`ifdef BRANCH_PREDICT_STATS_EN
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] mispred_cnt_q, mispred_cnt_d;

  always_comb begin
    branch_cnt_d  = branch_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (resolve && branch_cnt_q != 32'hFFFF_FFFF)     branch_cnt_d  = branch_cnt_q + 32'd1;
    if (mispredict && mispred_cnt_q != 32'hFFFF_FFFF) mispred_cnt_d = mispred_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      branch_cnt_q  <= 32'd0;
      mispred_cnt_q <= 32'd0;
    end else begin
      branch_cnt_q  <= branch_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign o_branch_cnt  = branch_cnt_q;
  assign o_mispred_cnt = mispred_cnt_q;
`endif

endmodule

// File: doc/branch_predict_ctrl.md
BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

Interface
REQ-001 Parameter BHT_ENTRIES, default 16: number of 2-bit counters; power of two, 4..256.
REQ-002 Parameter RECOVER_CYCLES, default 1: cycles in RECOVER after a redirect; range 1..7.
REQ-003 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1: synchronous, active-low reset.
REQ-005 Ports on the fetch side:
- i_if_pc  in  32: fetch PC.
- i_if_instr  in  32: fetched instruction.
- o_pred_taken  out  1: fetch redirect predicted.
- o_pred_pc  out  32: predicted next PC.
REQ-006 Ports on the execute side:
- i_ex_valid  in  1: EX holds a real instruction.
- i_ex_is_branch  in  1: conditional branch.
- i_ex_is_jump  in  1: JAL or JALR.
- i_ex_pc  in  32: EX PC.
- i_ex_taken  in  1: actual outcome.
- i_ex_target  in  32: actual target.
- i_ex_pred_taken  in  1: prediction carried down the pipe.
- i_ex_pred_pc  in  32: prediction carried down the pipe.
REQ-007 Port i_stall  in  1: pipeline frozen this cycle.
REQ-008 Ports on the redirect side:
- o_redirect  out  1: mispredict redirect.
- o_redirect_pc  out  32: corrected PC.
- o_flush  out  1: squash IF/ID and ID/EX.
- o_recover  out  1: FSM in RECOVER.

Function
REQ-009 Prediction SHALL be combinational from i_if_instr/i_if_pc, with zero latency.
REQ-010 Opcode bits [6:2]=11011 (JAL): o_pred_taken=1; o_pred_pc=i_if_pc+sign-extended J-immediate.
REQ-011 Opcode bits [6:2]=11000 (branch):
- o_pred_taken=BHT[idx][1], where idx=i_if_pc[log2(BHT_ENTRIES)+1:2].
- o_pred_pc=i_if_pc+B-immediate when taken, else i_if_pc+4.
REQ-012 Any other opcode, JALR included: o_pred_taken=0; o_pred_pc=i_if_pc+4.
REQ-013 All PC arithmetic SHALL be 32-bit modulo 2^32; wrap-around is permitted and not flagged.
REQ-014 A resolve event SHALL be defined as: i_ex_valid & (i_ex_is_branch | i_ex_is_jump) & !i_stall & state==RUN.
REQ-015 On a resolve event where i_ex_is_branch=1, the entry indexed by i_ex_pc SHALL be updated at the clock edge:
- i_ex_taken=1: saturating increment, max 3.
- i_ex_taken=0: saturating decrement, min 0.
REQ-016 Mispredict SHALL be defined as a resolve event with either:
- i_ex_taken != i_ex_pred_taken, or
- i_ex_taken=1 and i_ex_target != i_ex_pred_pc.
REQ-017 On a mispredict, in the same cycle (combinational):
- o_redirect=1 and o_flush=1.
- o_redirect_pc=i_ex_target if i_ex_taken, else i_ex_pc+4.
REQ-018 When not mispredicting: o_redirect=0, o_flush=0, o_redirect_pc=0.
REQ-019 The FSM SHALL have two states:
- RUN to RECOVER on a mispredict, loading the counter with RECOVER_CYCLES.
- RECOVER decrements the counter every cycle, including stall cycles, and returns to RUN when the counter reaches 1.
REQ-020 In RECOVER: o_recover=1; EX inputs are ignored (no BHT update, no redirect); prediction is unaffected.
REQ-021 If the BHT read index equals the update index in the same cycle, the read SHALL return the pre-update value.
REQ-022 A stalled cycle SHALL cause neither a BHT update nor a redirect.

Reset
REQ-023 While reset=0 at a clock edge:
- State SHALL go to RUN.
- Every BHT entry SHALL be set to 2'b01.
- The recovery counter SHALL be set to 0.
- All statistics counters SHALL be set to 0.
REQ-024 Reset SHALL take priority over every other event, including a mispredict or RECOVER in progress.
REQ-025 Combinational outputs SHALL follow their inputs during reset; o_recover=0 in the cycle after reset.

Configuration
REQ-026 Macro BRANCH_PREDICT_STATS_EN defined SHALL add:
- o_branch_cnt  out  32: counts resolve events.
- o_mispred_cnt  out  32: counts mispredicts.
- Both counters are registered and saturate at 32'hFFFFFFFF.
REQ-027 Macro undefined: both ports and their counters SHALL be absent; all other behaviour identical.

Verification
REQ-028 After reset, fetch BEQ at pc=0x100 with B-imm=+16 -> o_pred_taken=0, o_pred_pc=0x104.
REQ-029 JAL at pc=0x200 with imm=-8 -> o_pred_taken=1, o_pred_pc=0x1F8, independent of BHT.
REQ-030 Three resolve events for taken branch pc=0x100 -> counter values 2, 3, 3; next fetch of 0x100 predicts taken toward 0x110.
REQ-031 EX branch resolves not-taken at pc=0x100 after a taken prediction -> same cycle o_redirect=1, o_flush=1, o_redirect_pc=0x104; next cycle o_recover=1 and a valid EX branch is ignored.
REQ-032 JALR at pc=0x300 resolving to 0x40 with pred 0x304 -> redirect to 0x40; the same mispredict held under i_stall=1 gives no redirect until the stall drops.
REQ-033 Reset=0 asserted during RECOVER -> RUN next cycle, BHT entries=1; with BRANCH_PREDICT_STATS_EN defined, both counters=0.
